sipo_rx: RTL and testbench

Serial-in, parallel-out frame receiver that consumes the single-bit stream produced by the team's PISO transmit shift register. The line idles high. A frame is one start bit (0), WIDTH data bits LSB first, and one stop bit (1), at one bit per clock. The block detects the start bit, assembles the data word, checks the stop bit, and presents the word with a one-cycle valid strobe, or flags a framing error. It sits directly downstream of the PISO stage on the same clock, with no oversampling.

---
 rtl/sipo_rx_if.sv | 14 +
 rtl/sipo_rx.sv | 91 +++++++++
 tb/tb_sipo_rx.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/sipo_rx_if.sv
// Receiver-side bundle for the PISO/SIPO serial link: the serial line plus the
// recovered word and its status strobes.
interface sipo_rx_if #(
  parameter int WIDTH = 8
);
  logic             serial_in;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             frame_err;
  logic             busy;

  modport master (output serial_in, input data, valid, frame_err, busy);
  modport slave  (input serial_in, output data, valid, frame_err, busy);
endinterface

// File: rtl/sipo_rx.sv
// Serial-in parallel-out frame receiver: start bit 0, WIDTH data bits LSB first,
// stop bit 1, one bit per clock, no oversampling.
module sipo_rx #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  sipo_rx_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, DATA, STOP, RESYNC} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [WIDTH-1:0] data_q, data_next;
  logic             valid_q, valid_next;
  logic             err_q, err_next;
  logic             busy_q;

  // Next-state and next-output decode; strobes default low so they last one cycle.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    shift_next = shift_reg;
    data_next  = data_q;
    valid_next = 1'b0;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.serial_in) begin
          state_next = DATA;
          cnt_next   = '0;
          shift_next = '0;
        end
      end
      DATA: begin
        shift_next = {bus.serial_in, shift_reg[WIDTH-1:1]};
        cnt_next   = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          state_next = STOP;
        end
      end
      STOP: begin
        if (bus.serial_in) begin
          data_next  = shift_reg;
          valid_next = 1'b1;
          state_next = IDLE;
        end else begin
          err_next   = 1'b1;
          state_next = RESYNC;
        end
      end
      RESYNC: begin
        // A low line here is the tail of a bad frame, never a new start bit.
        if (bus.serial_in) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      shift_reg <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      shift_reg <= shift_next;
      data_q    <= data_next;
      valid_q   <= valid_next;
      err_q     <= err_next;
      busy_q    <= (state_next != IDLE);
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = err_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx: table of framed words, break/reset corner cases,
// and a behavioural PISO loopback.
module tb_sipo_rx;
  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  logic line_bit;
  logic use_piso;
  logic load;
  logic [7:0] piso_data;
  logic [9:0] piso_frame;

  int tests_run;
  int tests_failed;

  sipo_rx_if #(.WIDTH(WIDTH)) bus ();

  sipo_rx #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.serial_in = use_piso ? piso_frame[0] : line_bit;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream PISO: a load at edge L puts the start bit on the line right after L.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      piso_frame <= '1;
    end else if (load) begin
      piso_frame <= {1'b1, piso_data, 1'b0};
    end else begin
      piso_frame <= {1'b1, piso_frame[9:1]};
    end
  end

  typedef struct {
    logic [7:0] word;
    logic       stop_bit;
    int         gap;
    logic       exp_valid;
    logic       exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic driveBit(input logic b);
    line_bit = b;
    @(posedge clk);
    #1;
  endtask

  // Sends one full frame; every cycle before the stop edge must be free of strobes.
  task automatic applyStimulus(input logic [7:0] w, input logic stop_bit,
                               output int busy_cycles);
    busy_cycles = 0;
    driveBit(1'b0);
    busy_cycles += int'(bus.busy);
    checkOutput("start_no_pulse", {14'd0, bus.valid, bus.frame_err}, 16'd0);
    for (int i = 0; i < 8; i++) begin
      driveBit(w[i]);
      busy_cycles += int'(bus.busy);
      checkOutput("data_no_pulse", {14'd0, bus.valid, bus.frame_err}, 16'd0);
    end
    driveBit(stop_bit);
    busy_cycles += int'(bus.busy);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busy_cycles;
    int n_valid;
    int n_err;
    int n_busy_low;
    logic [7:0] piso_words[4];

    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b0;
    line_bit  = 1'b1;
    use_piso  = 1'b0;
    load      = 1'b0;
    piso_data = 8'h00;

    vecs[0] = '{8'h81, 1'b0, 2, 1'b0, 1'b1, 8'h00};
    vecs[1] = '{8'h42, 1'b1, 1, 1'b1, 1'b0, 8'h42};
    vecs[2] = '{8'hA5, 1'b1, 1, 1'b1, 1'b0, 8'hA5};
    vecs[3] = '{8'h3C, 1'b1, 0, 1'b1, 1'b0, 8'h3C};
    vecs[4] = '{8'hFF, 1'b1, 2, 1'b1, 1'b0, 8'hFF};
    vecs[5] = '{8'h00, 1'b1, 0, 1'b1, 1'b0, 8'h00};
    vecs[6] = '{8'h5A, 1'b1, 1, 1'b1, 1'b0, 8'h5A};

    // Asynchronous reset asserted between edges, checked before any clock.
    #3 rst = 1'b1;
    #1;
    checkOutput("reset_data",  {8'd0, bus.data}, 16'h0000);
    checkOutput("reset_valid", {15'd0, bus.valid}, 16'd0);
    checkOutput("reset_err",   {15'd0, bus.frame_err}, 16'd0);
    checkOutput("reset_busy",  {15'd0, bus.busy}, 16'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      driveBit(1'b1);
      checkOutput("idle_quiet", {13'd0, bus.busy, bus.valid, bus.frame_err}, 16'd0);
    end

    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].word, vecs[v].stop_bit, busy_cycles);
      checkOutput("vec_valid", {15'd0, bus.valid}, {15'd0, vecs[v].exp_valid});
      checkOutput("vec_err",   {15'd0, bus.frame_err}, {15'd0, vecs[v].exp_err});
      checkOutput("vec_data",  {8'd0, bus.data}, {8'd0, vecs[v].exp_data});
      checkOutput("vec_busy_cycles", 16'(busy_cycles), vecs[v].stop_bit ? 16'd9 : 16'd10);
      for (int g = 0; g < vecs[v].gap; g++) begin
        driveBit(1'b1);
        checkOutput("gap_quiet", {13'd0, bus.busy, bus.valid, bus.frame_err}, 16'd0);
      end
    end

    // Break: line held low for 20 cycles gives exactly one frame_err and no valid.
    n_valid = 0;
    n_err = 0;
    n_busy_low = 0;
    for (int i = 0; i < 20; i++) begin
      driveBit(1'b0);
      n_valid += int'(bus.valid);
      n_err += int'(bus.frame_err);
      n_busy_low += int'(!bus.busy);
    end
    checkOutput("break_valid_count", 16'(n_valid), 16'd0);
    checkOutput("break_err_count", 16'(n_err), 16'd1);
    checkOutput("break_busy_low", 16'(n_busy_low), 16'd0);
    checkOutput("break_data_held", {8'd0, bus.data}, 16'h005A);
    driveBit(1'b1);
    checkOutput("break_release_busy", {15'd0, bus.busy}, 16'd0);
    driveBit(1'b1);

    // Reset mid-frame: start of 0x55, then rst between edges before edge S+4.
    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b0);
    driveBit(1'b1);
    checkOutput("midframe_busy", {15'd0, bus.busy}, 16'd1);
    line_bit = 1'b1;
    #2 rst = 1'b1;
    #1;
    checkOutput("midreset_busy", {15'd0, bus.busy}, 16'd0);
    checkOutput("midreset_data", {8'd0, bus.data}, 16'h0000);
    checkOutput("midreset_strobes", {14'd0, bus.valid, bus.frame_err}, 16'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    n_valid = 0;
    n_err = 0;
    for (int i = 0; i < 12; i++) begin
      driveBit(1'b1);
      n_valid += int'(bus.valid);
      n_err += int'(bus.frame_err);
    end
    checkOutput("postreset_no_valid", 16'(n_valid), 16'd0);
    checkOutput("postreset_no_err", 16'(n_err), 16'd0);
    applyStimulus(8'h0F, 1'b1, busy_cycles);
    checkOutput("after_reset_valid", {15'd0, bus.valid}, 16'd1);
    checkOutput("after_reset_data", {8'd0, bus.data}, 16'h000F);
    driveBit(1'b1);
    driveBit(1'b1);

    // PISO loopback, reloaded every WIDTH+2 cycles.
    piso_words[0] = 8'hC3;
    piso_words[1] = 8'h00;
    piso_words[2] = 8'hFF;
    piso_words[3] = 8'h5A;
    use_piso = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        load = 1'b1;
        piso_data = piso_words[i];
      end
      @(posedge clk);
      #1 load = 1'b0;
      if (i > 0) begin
        checkOutput("piso_valid", {14'd0, bus.valid, bus.frame_err}, 16'd2);
        checkOutput("piso_data", {8'd0, bus.data}, {8'd0, piso_words[i-1]});
      end
      if (i < 4) begin
        for (int k = 0; k < 9; k++) begin
          @(posedge clk);
          #1;
          checkOutput("piso_no_pulse", {14'd0, bus.valid, bus.frame_err}, 16'd0);
        end
      end
    end
    driveBit(1'b1);
    checkOutput("piso_idle_busy", {15'd0, bus.busy}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
